// File: rtl/wb_port_arbiter.sv
// Purpose:      merges pipeline writeback with queued multi-cycle mul/div results onto one register-file write port.
// Latency:      pipeline writes pass through combinationally; an MDU result is written no earlier than 1 cycle after its push.
// Backpressure: o_mdu_rdy drops when the 2-entry result queue is full; o_wb_stall holds the pipeline while a starved entry drains.
//
// Ports:
//   i_clk, i_rst                              clock (rising edge), asynchronous active-high reset
//   i_pipe_wr_en, i_pipe_rd_idx, i_pipe_rd_data  pipeline writeback request
//   i_mdu_vld, o_mdu_rdy, i_mdu_rd_idx, i_mdu_data  MDU result handshake
//   o_wb_stall                                pipeline must hold its writeback inputs this cycle
//   o_rf_wr_en, o_rf_wr_idx, o_rf_wr_data     register-file write port
//   o_q_cnt                                   MDU result queue occupancy (0..2)
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pipe_wr_en,
    input  logic [4:0]  i_pipe_rd_idx,
    input  logic [31:0] i_pipe_rd_data,
    input  logic        i_mdu_vld,
    output logic        o_mdu_rdy,
    input  logic [4:0]  i_mdu_rd_idx,
    input  logic [31:0] i_mdu_data,
    output logic        o_wb_stall,
    output logic        o_rf_wr_en,
    output logic [4:0]  o_rf_wr_idx,
    output logic [31:0] o_rf_wr_data,
    output logic [1:0]  o_q_cnt
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    // Result queue storage: index + data per entry.
    logic [4:0]  idx_q  [0:1];
    logic [31:0] data_q [0:1];

    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  cnt_q,    cnt_d;
    logic [3:0]  starve_q, starve_d;

    logic        push;
    logic        pop;
    logic        grant;
    logic [4:0]  head_idx;
    logic [31:0] head_data;

    assign head_idx  = idx_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];

    // Readiness depends only on registered occupancy, never on a same-cycle pop,
    // so there is no combinational path from the pipeline back to the MDU.
    assign push = i_mdu_vld && (cnt_q != 2'd2) && !i_rst;

    // The queue only wins the port when the pipeline is idle or the head has waited
    // long enough. Entries pushed this cycle are not visible until cnt_q updates.
    assign grant = (cnt_q != 2'd0) && (!i_pipe_wr_en || (starve_q == STARVE_MAX));
    assign pop   = grant;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        starve_d = starve_q;

        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase

        // Age of the current head while the pipeline keeps the port busy.
        if (pop || (cnt_q == 2'd0)) begin
            starve_d = 4'd0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            starve_q <= 4'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
        end
    end

    // Payload storage needs no reset: occupancy alone says which entries are live.
    always_ff @(posedge i_clk) begin
        if (push) begin
            idx_q[wr_ptr_q]  <= i_mdu_rd_idx;
            data_q[wr_ptr_q] <= i_mdu_data;
        end
    end

    // Outputs are forced quiet while reset is held, independent of pipeline inputs.
    always_comb begin
        o_mdu_rdy    = 1'b0;
        o_wb_stall   = 1'b0;
        o_rf_wr_en   = 1'b0;
        o_rf_wr_idx  = 5'd0;
        o_rf_wr_data = 32'd0;
        o_q_cnt      = 2'd0;
        if (!i_rst) begin
            o_mdu_rdy  = (cnt_q != 2'd2);
            o_wb_stall = i_pipe_wr_en && grant;
            o_q_cnt    = cnt_q;
            if (grant) begin
                // An x0 head still drains; only the write itself is suppressed.
                o_rf_wr_en   = (head_idx != 5'd0);
                o_rf_wr_idx  = head_idx;
                o_rf_wr_data = head_data;
            end else begin
                o_rf_wr_en   = i_pipe_wr_en && (i_pipe_rd_idx != 5'd0);
                o_rf_wr_idx  = i_pipe_rd_idx;
                o_rf_wr_data = i_pipe_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Purpose:      directed self-checking bench for wb_port_arbiter (STARVE_LIMIT = 4).
// Latency:      inputs driven just after each falling edge, outputs checked 1 time unit later.
// Backpressure: exercises full-queue refusal, starvation stall and reset discard.
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        pipe_wr_en;
    logic [4:0]  pipe_rd_idx;
    logic [31:0] pipe_rd_data;
    logic        mdu_vld;
    logic        mdu_rdy;
    logic [4:0]  mdu_rd_idx;
    logic [31:0] mdu_data;
    logic        wb_stall;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_idx;
    logic [31:0] rf_wr_data;
    logic [1:0]  q_cnt;

    int passed = 0;
    int total  = 0;

    wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_pipe_wr_en   (pipe_wr_en),
        .i_pipe_rd_idx  (pipe_rd_idx),
        .i_pipe_rd_data (pipe_rd_data),
        .i_mdu_vld      (mdu_vld),
        .o_mdu_rdy      (mdu_rdy),
        .i_mdu_rd_idx   (mdu_rd_idx),
        .i_mdu_data     (mdu_data),
        .o_wb_stall     (wb_stall),
        .o_rf_wr_en     (rf_wr_en),
        .o_rf_wr_idx    (rf_wr_idx),
        .o_rf_wr_data   (rf_wr_data),
        .o_q_cnt        (q_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input logic pwe, input logic [4:0] pidx, input logic [31:0] pdat,
                         input logic mv, input logic [4:0] midx, input logic [31:0] mdat);
        pipe_wr_en   = pwe;
        pipe_rd_idx  = pidx;
        pipe_rd_data = pdat;
        mdu_vld      = mv;
        mdu_rd_idx   = midx;
        mdu_data     = mdat;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        // Pipeline active during reset: outputs must still be quiet.
        drive(1'b1, 5'd5, 32'h1234, 1'b1, 5'd1, 32'h1);
        #1;
        chk("rst_rdy",      32'(mdu_rdy),    32'd0);
        chk("rst_stall",    32'(wb_stall),   32'd0);
        chk("rst_wr_en",    32'(rf_wr_en),   32'd0);
        chk("rst_wr_idx",   32'(rf_wr_idx),  32'd0);
        chk("rst_wr_data",  rf_wr_data,      32'd0);
        chk("rst_q_cnt",    32'(q_cnt),      32'd0);

        // Release reset; rdy is high in the first cycle.
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("rel_rdy",      32'(mdu_rdy),    32'd1);
        chk("rel_wr_en",    32'(rf_wr_en),   32'd0);

        // Idle queue: pipeline passes straight through.
        next_cycle();
        drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0);
        #1;
        chk("idle_wr_en",   32'(rf_wr_en),   32'd1);
        chk("idle_wr_idx",  32'(rf_wr_idx),  32'd5);
        chk("idle_wr_data", rf_wr_data,      32'h1234);
        chk("idle_stall",   32'(wb_stall),   32'd0);

        // MDU result on an idle pipeline: not written in its push cycle.
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hDEAD);
        #1;
        chk("mdu_n_wr_en",  32'(rf_wr_en),   32'd0);
        chk("mdu_n_q_cnt",  32'(q_cnt),      32'd0);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("mdu_n1_q_cnt", 32'(q_cnt),      32'd1);
        chk("mdu_n1_wr_en", 32'(rf_wr_en),   32'd1);
        chk("mdu_n1_idx",   32'(rf_wr_idx),  32'd7);
        chk("mdu_n1_data",  rf_wr_data,      32'hDEAD);
        chk("mdu_n1_stall", 32'(wb_stall),   32'd0);
        next_cycle();
        #1;
        chk("mdu_n2_q_cnt", 32'(q_cnt),      32'd0);
        chk("mdu_n2_wr_en", 32'(rf_wr_en),   32'd0);

        // Starvation: pipeline busy for 4 cycles after the entry lands, then one stall.
        next_cycle();
        drive(1'b1, 5'd3, 32'h30, 1'b1, 5'd9, 32'h99);
        #1;
        chk("stv_push_idx", 32'(rf_wr_idx),  32'd3);
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            drive(1'b1, 5'd3, 32'h30 + 32'(k), 1'b0, 5'd0, 32'h0);
            #1;
            chk($sformatf("stv_wait%0d_stall", k), 32'(wb_stall),  32'd0);
            chk($sformatf("stv_wait%0d_data", k),  rf_wr_data,     32'h30 + 32'(k));
            chk($sformatf("stv_wait%0d_q_cnt", k), 32'(q_cnt),     32'd1);
        end
        next_cycle();
        drive(1'b1, 5'd3, 32'h35, 1'b0, 5'd0, 32'h0);
        #1;
        chk("stv_stall",    32'(wb_stall),   32'd1);
        chk("stv_wr_en",    32'(rf_wr_en),   32'd1);
        chk("stv_idx",      32'(rf_wr_idx),  32'd9);
        chk("stv_data",     rf_wr_data,      32'h99);
        next_cycle();
        #1;
        chk("stv_after_stall", 32'(wb_stall), 32'd0);
        chk("stv_after_q_cnt", 32'(q_cnt),    32'd0);
        chk("stv_after_data",  rf_wr_data,    32'h35);

        // Full queue with pipeline busy; third valid ignored.
        next_cycle();
        drive(1'b1, 5'd4, 32'h40, 1'b1, 5'd10, 32'hA);
        next_cycle();
        drive(1'b1, 5'd4, 32'h40, 1'b1, 5'd11, 32'hB);
        #1;
        chk("full_b1_q_cnt", 32'(q_cnt),     32'd1);
        chk("full_b1_rdy",   32'(mdu_rdy),   32'd1);
        next_cycle();
        drive(1'b1, 5'd4, 32'h40, 1'b1, 5'd12, 32'hC);
        #1;
        chk("full_b2_q_cnt", 32'(q_cnt),     32'd2);
        chk("full_b2_rdy",   32'(mdu_rdy),   32'd0);
        chk("full_b2_idx",   32'(rf_wr_idx), 32'd4);
        // Pipeline goes idle: head drains, rdy stays low until the pop lands.
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("full_b3_q_cnt", 32'(q_cnt),     32'd2);
        chk("full_b3_rdy",   32'(mdu_rdy),   32'd0);
        chk("full_b3_idx",   32'(rf_wr_idx), 32'd10);
        chk("full_b3_data",  rf_wr_data,     32'hA);
        chk("full_b3_stall", 32'(wb_stall),  32'd0);
        // Simultaneous push and pop keeps occupancy.
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'hD);
        #1;
        chk("full_b4_q_cnt", 32'(q_cnt),     32'd1);
        chk("full_b4_rdy",   32'(mdu_rdy),   32'd1);
        chk("full_b4_idx",   32'(rf_wr_idx), 32'd11);
        chk("full_b4_data",  rf_wr_data,     32'hB);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("full_b5_q_cnt", 32'(q_cnt),     32'd1);
        chk("full_b5_idx",   32'(rf_wr_idx), 32'd13);
        chk("full_b5_data",  rf_wr_data,     32'hD);
        next_cycle();
        #1;
        chk("full_b6_q_cnt", 32'(q_cnt),     32'd0);

        // x0 head: write suppressed but entry still pops.
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("x0_q_cnt",     32'(q_cnt),      32'd1);
        chk("x0_wr_en",     32'(rf_wr_en),   32'd0);
        next_cycle();
        #1;
        chk("x0_pop_q_cnt", 32'(q_cnt),      32'd0);

        // Reset mid-cycle with a full queue discards both entries.
        next_cycle();
        drive(1'b1, 5'd4, 32'h40, 1'b1, 5'd20, 32'h20);
        next_cycle();
        drive(1'b1, 5'd4, 32'h40, 1'b1, 5'd21, 32'h21);
        next_cycle();
        drive(1'b1, 5'd4, 32'h40, 1'b0, 5'd0, 32'h0);
        #1;
        chk("rstq_pre_q_cnt", 32'(q_cnt),    32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("rstq_q_cnt",    32'(q_cnt),     32'd0);
        chk("rstq_wr_en",    32'(rf_wr_en),  32'd0);
        chk("rstq_rdy",      32'(mdu_rdy),   32'd0);
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("rstq_rel_wr_en", 32'(rf_wr_en), 32'd0);
        chk("rstq_rel_q_cnt", 32'(q_cnt),    32'd0);
        chk("rstq_rel_rdy",   32'(mdu_rdy),  32'd1);
        next_cycle();
        #1;
        chk("rstq_rel2_wr_en", 32'(rf_wr_en), 32'd0);
        chk("rstq_rel2_q_cnt", 32'(q_cnt),    32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
